// File: rtl/jtdd_tilemap.sv
// Scrolling tilemap: CPU tile RAM, 2-pixel ROM fetch, 4-tick pixel pipe.
// Define JTDD_TILEMAP_SCROLL_EN to enable line-latched h/v scroll.
module jtdd_tilemap #(
  parameter int HBITS = 5,
  parameter int VBITS = 5,
  parameter int CODEW = 10,
  parameter int PALW  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   cen_E,
  input  logic [HBITS+VBITS:0]   cpu_AB,
  input  logic                   tile_cs,
  input  logic                   cpu_wrn,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             tile_dout,
  input  logic [7:0]             HPOS,
  input  logic [7:0]             VPOS,
  input  logic                   flip,
  input  logic [HBITS+2:0]       hscroll,
  input  logic [VBITS+2:0]       vscroll,
  output logic [CODEW+4:0]       rom_addr,
  input  logic [7:0]             rom_data,
  input  logic                   rom_ok,
  output logic                   rom_miss,
  output logic [PALW+3:0]        pxl
);

  localparam int AW = HBITS + VBITS;
  localparam int HW = HBITS + 3;
  localparam int VW = VBITS + 3;

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} st_t;

  logic [7:0] lo_mem [0:(1<<AW)-1];
  logic [7:0] hi_mem [0:(1<<AW)-1];

  logic [AW-1:0] scan_a;
  logic [AW-1:0] ram_a;
  logic [7:0]    lo_rd;
  logic [7:0]    hi_rd;
  logic [7:0]    hf;
  logic [7:0]    vf;
  logic [HW-1:0] hx;
  logic [VW-1:0] vx;
  logic [HW-1:0] eh;
  logic [VW-1:0] ev;
  logic [CODEW-1:0] code;
  logic [3:0]    odd_b;
  logic [3:0]    even_b;
  logic [3:0]    fst;
  logic [3:0]    sec;

  st_t             st_q;
  logic            fetch_v_q;
  logic [CODEW+4:0] rom_addr_q;
  logic [PALW-1:0] pal_f_q;
  logic [PALW-1:0] pal_q;
  logic [7:0]      pair_q;
  logic [PALW+3:0] pre_q;
  logic [PALW+3:0] pxl_q;
  logic            miss_q;

  // CPU owns the RAM port whenever selected
  assign ram_a     = tile_cs ? cpu_AB[AW:1] : scan_a;
  assign lo_rd     = lo_mem[ram_a];
  assign hi_rd     = hi_mem[ram_a];
  assign tile_dout = cpu_AB[0] ? hi_rd : lo_rd;

  always_ff @(posedge clk) begin
    if (cen_E && tile_cs && !cpu_wrn) begin
      if (cpu_AB[0]) hi_mem[cpu_AB[AW:1]] <= cpu_dout;
      else           lo_mem[cpu_AB[AW:1]] <= cpu_dout;
    end
  end

  assign hf = flip ? ~HPOS : HPOS;
  assign vf = flip ? ~VPOS : VPOS;
  assign hx = HW'(hf);
  assign vx = VW'(vf);

`ifdef JTDD_TILEMAP_SCROLL_EN
  logic [HW-1:0] hs_q;
  logic [VW-1:0] vs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q <= '0;
      vs_q <= '0;
    end else if (pxl_cen && HPOS == 8'd0) begin
      hs_q <= hscroll;
      vs_q <= vscroll;
    end
  end

  assign eh = hx + hs_q;
  assign ev = vx + vs_q;
`else
  logic unused_scroll;
  assign unused_scroll = ^{hscroll, vscroll};
  assign eh = hx;
  assign ev = vx;
`endif

  assign scan_a = {ev[VW-1:3], eh[HW-1:3]};
  assign code   = CODEW'({hi_rd, lo_rd});

  assign odd_b  = {pair_q[7], pair_q[5], pair_q[3], pair_q[1]};
  assign even_b = {pair_q[6], pair_q[4], pair_q[2], pair_q[0]};
  assign fst    = flip ? even_b : odd_b;
  assign sec    = flip ? odd_b : even_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= EVEN;
      fetch_v_q  <= 1'b0;
      rom_addr_q <= '0;
      pal_f_q    <= '0;
      pal_q      <= '0;
      pair_q     <= '0;
      pre_q      <= '0;
      pxl_q      <= '0;
      miss_q     <= 1'b0;
    end else begin
      miss_q <= 1'b0;
      if (pxl_cen) begin
        pxl_q <= pre_q;
        if (!eh[0]) begin
          st_q       <= ODD;
          fetch_v_q  <= 1'b1;
          rom_addr_q <= {code, eh[2:1], ev[2:0] ^ {3{flip}}};
          pal_f_q    <= hi_rd[7 -: PALW];
          pre_q      <= {pal_q, sec};
          // a late byte blanks the pair but keeps the old palette
          if (fetch_v_q && rom_ok) begin
            pair_q <= rom_data;
            pal_q  <= pal_f_q;
          end else begin
            pair_q <= '0;
            miss_q <= fetch_v_q;
          end
        end else begin
          st_q <= EVEN;
          if (st_q == ODD) pre_q <= {pal_q, fst};
        end
      end
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_miss = miss_q;
  assign pxl      = pxl_q;

endmodule

// File: tb/tb_jtdd_tilemap.sv
// Directed bench for jtdd_tilemap: CPU RAM, fetch, pixels, miss, scroll,
// flip and mid-line reset.
module tb_jtdd_tilemap;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        cen_E = 1'b0;
  logic [10:0] cpu_AB = '0;
  logic        tile_cs = 1'b0;
  logic        cpu_wrn = 1'b1;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  tile_dout;
  logic [7:0]  HPOS = '0;
  logic [7:0]  VPOS = '0;
  logic        flip = 1'b0;
  logic [7:0]  hscroll = '0;
  logic [7:0]  vscroll = '0;
  logic [14:0] rom_addr;
  logic [7:0]  rom_data = 8'h5A;
  logic        rom_ok = 1'b1;
  logic        rom_miss;
  logic [6:0]  pxl;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m1;
  logic m2;

  jtdd_tilemap dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .cen_E    (cen_E),
    .cpu_AB   (cpu_AB),
    .tile_cs  (tile_cs),
    .cpu_wrn  (cpu_wrn),
    .cpu_dout (cpu_dout),
    .tile_dout(tile_dout),
    .HPOS     (HPOS),
    .VPOS     (VPOS),
    .flip     (flip),
    .hscroll  (hscroll),
    .vscroll  (vscroll),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_ok   (rom_ok),
    .rom_miss (rom_miss),
    .pxl      (pxl)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic tick(input logic [7:0] h);
    HPOS = h;
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    m1 = rom_miss;
    pxl_cen = 1'b0;
    @(posedge clk); #1;
    m2 = rom_miss;
  endtask

  task automatic cpu_wr(input logic [9:0] a, input logic hi,
                        input logic [7:0] d);
    cpu_AB = {a, hi};
    cpu_dout = d;
    tile_cs = 1'b1;
    cpu_wrn = 1'b0;
    cen_E = 1'b1;
    @(posedge clk); #1;
    tile_cs = 1'b0;
    cpu_wrn = 1'b1;
    cen_E = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (pxl !== 7'h00) begin
      n_bad++;
      $display("FAIL reset_pxl: got %h want 00", pxl);
    end
    n_cmp++;
    if (rom_addr !== 15'h0000) begin
      n_bad++;
      $display("FAIL reset_rom_addr: got %h want 0000", rom_addr);
    end
    n_cmp++;
    if (rom_miss !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rom_miss: got %b want 0", rom_miss);
    end
  endtask

  task automatic test_cpu();
    cpu_wr(10'h021, 1'b0, 8'h34);
    cpu_wr(10'h021, 1'b1, 8'hA1);
    tile_cs = 1'b1;
    cpu_AB = {10'h021, 1'b0};
    #1;
    n_cmp++;
    if (tile_dout !== 8'h34) begin
      n_bad++;
      $display("FAIL cpu_rd_lo: got %h want 34", tile_dout);
    end
    cpu_AB = {10'h021, 1'b1};
    #1;
    n_cmp++;
    if (tile_dout !== 8'hA1) begin
      n_bad++;
      $display("FAIL cpu_rd_hi: got %h want a1", tile_dout);
    end
    tile_cs = 1'b0;
    cpu_AB = '0;
  endtask

  task automatic test_pixels();
    logic [6:0] exp;
    do_reset();
    VPOS = 8'd8;
    for (int k = 0; k < 8; k++) begin
      tick(8'(8 + k));
      if (k == 0) begin
        n_cmp++;
        if (rom_addr !== 15'h2680) begin
          n_bad++;
          $display("FAIL pix_rom_addr: got %h want 2680", rom_addr);
        end
      end
      if (k >= 4) begin
        exp = (k % 2 == 0) ? 7'h53 : 7'h5C;
        n_cmp++;
        if (pxl !== exp) begin
          n_bad++;
          $display("FAIL pix_k%0d: got %h want %h", k, pxl, exp);
        end
      end
    end
  endtask

  task automatic test_miss();
    logic [6:0] exp;
    do_reset();
    VPOS = 8'd8;
    for (int k = 0; k < 10; k++) begin
      rom_ok = (k != 4);
      tick(8'(8 + k));
      rom_ok = 1'b1;
      n_cmp++;
      if (m1 !== (k == 4)) begin
        n_bad++;
        $display("FAIL miss_pulse_k%0d: got %b want %b", k, m1, k == 4);
      end
      if (k == 4) begin
        n_cmp++;
        if (m2 !== 1'b0) begin
          n_bad++;
          $display("FAIL miss_width: got %b want 0", m2);
        end
      end
      if (k >= 4) begin
        if (k == 6 || k == 7) exp = 7'h50;
        else exp = (k % 2 == 0) ? 7'h53 : 7'h5C;
        n_cmp++;
        if (pxl !== exp) begin
          n_bad++;
          $display("FAIL miss_pix_k%0d: got %h want %h", k, pxl, exp);
        end
      end
    end
  endtask

  task automatic test_scroll();
    logic [14:0] e1, e2, e3, e4;
`ifdef JTDD_TILEMAP_SCROLL_EN
    e1 = 15'h2680; e2 = 15'h4EE0; e3 = 15'h2680; e4 = 15'h0AA0;
`else
    e1 = 15'h0AA0; e2 = 15'h6CC0; e3 = 15'h0AA0; e4 = 15'h0AA0;
`endif
    cpu_wr(10'h03E, 1'b0, 8'h77);
    cpu_wr(10'h03E, 1'b1, 8'h02);
    cpu_wr(10'h03F, 1'b0, 8'h66);
    cpu_wr(10'h03F, 1'b1, 8'h03);
    cpu_wr(10'h022, 1'b0, 8'h55);
    cpu_wr(10'h022, 1'b1, 8'h00);
    do_reset();
    VPOS = 8'd8;
    hscroll = 8'hF8;
    tick(8'h00);
    tick(8'h10);
    n_cmp++;
    if (rom_addr !== e1) begin
      n_bad++;
      $display("FAIL scroll_col1: got %h want %h", rom_addr, e1);
    end
    tick(8'hF8);
    n_cmp++;
    if (rom_addr !== e2) begin
      n_bad++;
      $display("FAIL scroll_wrap: got %h want %h", rom_addr, e2);
    end
    hscroll = 8'h00;
    tick(8'h40);
    tick(8'h10);
    n_cmp++;
    if (rom_addr !== e3) begin
      n_bad++;
      $display("FAIL scroll_midline: got %h want %h", rom_addr, e3);
    end
    tick(8'h00);
    tick(8'h10);
    n_cmp++;
    if (rom_addr !== e4) begin
      n_bad++;
      $display("FAIL scroll_nextline: got %h want %h", rom_addr, e4);
    end
  endtask

  task automatic test_flip();
    cpu_wr(10'h3FF, 1'b0, 8'h12);
    cpu_wr(10'h3FF, 1'b1, 8'h40);
    do_reset();
    flip = 1'b1;
    VPOS = 8'd0;
    for (int k = 0; k < 6; k++) begin
      tick(8'(1 + k));
      if (k == 0) begin
        n_cmp++;
        if (rom_addr !== 15'h0258) begin
          n_bad++;
          $display("FAIL flip_addr0: got %h want 0258", rom_addr);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if (rom_addr !== 15'h0250) begin
          n_bad++;
          $display("FAIL flip_addr1: got %h want 0250", rom_addr);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (pxl !== 7'h2C) begin
          n_bad++;
          $display("FAIL flip_pix0: got %h want 2c", pxl);
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (pxl !== 7'h23) begin
          n_bad++;
          $display("FAIL flip_pix1: got %h want 23", pxl);
        end
      end
    end
    flip = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [6:0] exp;
    do_reset();
    VPOS = 8'd8;
    for (int k = 0; k < 5; k++) tick(8'(8 + k));
    n_cmp++;
    if (pxl !== 7'h53) begin
      n_bad++;
      $display("FAIL mrst_pre: got %h want 53", pxl);
    end
    do_reset();
    n_cmp++;
    if (pxl !== 7'h00) begin
      n_bad++;
      $display("FAIL mrst_pxl: got %h want 00", pxl);
    end
    n_cmp++;
    if (rom_addr !== 15'h0000) begin
      n_bad++;
      $display("FAIL mrst_rom_addr: got %h want 0000", rom_addr);
    end
    for (int k = 0; k < 6; k++) begin
      tick(8'(8 + k));
      if (k >= 1) begin
        if (k < 4) exp = 7'h00;
        else exp = (k == 4) ? 7'h53 : 7'h5C;
        n_cmp++;
        if (pxl !== exp) begin
          n_bad++;
          $display("FAIL mrst_pix_k%0d: got %h want %h", k, pxl, exp);
        end
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_cpu();
    test_pixels();
    test_miss();
    test_scroll();
    test_flip();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
